// File: rtl/axis_arb_pkg.sv
// Shared types and defaults for the AXI-Stream round-robin arbiter.
// The optional packet length limit is enabled by AXIS_ARB_MAXLEN_EN.
package axis_arb_pkg;

  localparam int unsigned DW_DEF     = 32'd8;
  localparam int unsigned NS_DEF     = 32'd4;
  localparam int unsigned MAXLEN_DEF = 32'd256;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Folds an index in [0, 2*ns) back into [0, ns).
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned ns);
    return (idx >= ns) ? (idx - ns) : idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter  int unsigned NS = NS_DEF,
  localparam int unsigned GW = $clog2(NS)
) (
  input  logic [NS-1:0] req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] gnt_idx,
  output logic          any_req
);

  logic [GW-1:0] cand_s;
  logic          hit_s;

  // Scan from ptr upward; the first hit wins and later hits are masked.
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int unsigned off = 0; off < NS; off++) begin
      cand_s  = GW'(rr_wrap(32'(ptr) + off, NS));
      hit_s   = ~any_req & req[cand_s];
      gnt_idx = hit_s ? cand_s : gnt_idx;
      any_req = any_req | hit_s;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging NS AXI-Stream inputs onto one output.
// Defining AXIS_ARB_MAXLEN_EN adds MAXLEN: longer packets are split by a forced tlast.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned NS = NS_DEF
`ifdef AXIS_ARB_MAXLEN_EN
  ,
  parameter int unsigned MAXLEN = MAXLEN_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NS*DW-1:0]      s_tdata,
  input  logic [NS-1:0]         s_tvalid,
  input  logic [NS-1:0]         s_tlast,
  output logic [NS-1:0]         s_tready,
  output logic [DW-1:0]         m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [$clog2(NS)-1:0] grant,
  output logic                  busy
);

  localparam int unsigned GW = $clog2(NS);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] grant_q, grant_d;

  logic [GW-1:0] pick_idx_s;
  logic          pick_any_s;
  logic [DW-1:0] s_data_a [NS];
  logic [DW-1:0] sel_data_s;
  logic          sel_valid_s;
  logic          sel_last_s;
  logic          force_last_s;
  logic          beat_s;
  logic          end_s;

  rr_pick #(.NS(NS)) u_pick (
    .req     (s_tvalid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx_s),
    .any_req (pick_any_s)
  );

  for (genvar i = 0; i < NS; i++) begin : g_unpack
    assign s_data_a[i] = s_tdata[i*DW +: DW];
  end

  assign sel_data_s  = s_data_a[grant_q];
  assign sel_valid_s = s_tvalid[grant_q];
  assign sel_last_s  = s_tlast[grant_q];

  // Output mux: pass-through from the owner while BUSY, fully quiet while IDLE.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    case (state_q)
      BUSY: begin
        m_tdata  = sel_data_s;
        m_tvalid = sel_valid_s;
        m_tlast  = sel_last_s | force_last_s;
        s_tready = {{(NS-1){1'b0}}, m_tready} << grant_q;
      end
      default: begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
      end
    endcase
  end

  assign beat_s = m_tvalid & m_tready;
  assign end_s  = beat_s & m_tlast;

  // Grant is only taken in IDLE and only released on a tlast beat, so bubbles hold it.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = BUSY;
          grant_d = pick_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (end_s) begin
          state_d = IDLE;
          ptr_d   = GW'(rr_wrap(32'(grant_q) + 32'd1, NS));
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

`ifdef AXIS_ARB_MAXLEN_EN
  localparam int unsigned CW = (MAXLEN > 32'd1) ? $clog2(MAXLEN) : 32'd1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds the number of beats already accepted in the current grant.
  assign force_last_s = (cnt_q == CW'(MAXLEN - 32'd1));

  // Beat counter: cleared outside BUSY and on every (real or forced) last beat.
  always_comb begin
    if (state_q != BUSY) begin
      cnt_d = '0;
    end else if (beat_s) begin
      cnt_d = m_tlast ? '0 : (cnt_q + CW'(1));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_last_s = 1'b0;
`endif

  assign grant = grant_q;
  assign busy  = (state_q == BUSY);

endmodule
